// File: rtl/range_stats_pkg.sv
// Shared definitions for range_stats: FSM state encoding and result-select codes.
package range_stats_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [1:0] SEL_RANGE = 2'd0;
  localparam logic [1:0] SEL_MIN   = 2'd1;
  localparam logic [1:0] SEL_MAX   = 2'd2;
  localparam logic [1:0] SEL_COUNT = 2'd3;

endpackage

// File: rtl/range_stats_seg7.sv
// Hex-digit to seven-segment decoder (active-high, bit order gfedcba).
// Compiled only when RANGE_STATS_SEG7_EN is defined, since only that build instantiates it.
`ifdef RANGE_STATS_SEG7_EN
module seg7 (
  input  logic [3:0] digit,
  output logic [6:0] segments
);

  always_comb begin
    segments = 7'h00;
    case (digit)
      4'h0: segments = 7'h3F;
      4'h1: segments = 7'h06;
      4'h2: segments = 7'h5B;
      4'h3: segments = 7'h4F;
      4'h4: segments = 7'h66;
      4'h5: segments = 7'h6D;
      4'h6: segments = 7'h7D;
      4'h7: segments = 7'h07;
      4'h8: segments = 7'h7F;
      4'h9: segments = 7'h6F;
      4'hA: segments = 7'h77;
      4'hB: segments = 7'h7C;
      4'hC: segments = 7'h39;
      4'hD: segments = 7'h5E;
      4'hE: segments = 7'h79;
      4'hF: segments = 7'h71;
      default: segments = 7'h00;
    endcase
  end

endmodule
`endif

// File: rtl/range_stats.sv
// Session-based min/max/count/range tracker with a four-state control FSM.
// Optional seven-segment output of result[3:0] when RANGE_STATS_SEG7_EN is defined.
module range_stats
  import range_stats_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             go,
  input  logic             finish,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       state_out,
  output logic             valid,
  output logic             error
`ifdef RANGE_STATS_SEG7_EN
  ,
  output logic [6:0]       segments
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] min_reg, min_next;
  logic [WIDTH-1:0] max_reg, max_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] range_val;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      min_reg   <= '1;
      max_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      min_reg   <= min_next;
      max_reg   <= max_next;
      count_reg <= count_next;
    end
  end

  // A strobe collision always wins over either strobe alone and freezes the statistics.
  always_comb begin
    state_next = state_reg;
    min_next   = min_reg;
    max_next   = max_reg;
    count_next = count_reg;
    if (go && finish) begin
      state_next = ST_ERROR;
    end else if (go) begin
      state_next = ST_ACCUM;
      if (state_reg == ST_ACCUM) begin
        if (data_in < min_reg) min_next = data_in;
        if (data_in > max_reg) max_next = data_in;
        if (count_reg != CNT_MAX) count_next = count_reg + CNT_W'(1);
      end else begin
        min_next   = data_in;
        max_next   = data_in;
        count_next = CNT_W'(1);
      end
    end else if (finish) begin
      state_next = (state_reg == ST_ACCUM) ? ST_DONE : ST_ERROR;
    end
  end

  // DONE is only reachable through ACCUM, so min <= max and the difference is never negative.
  assign range_val = max_reg - min_reg;

  always_comb begin
    result = '0;
    if (state_reg == ST_DONE) begin
      case (sel)
        SEL_RANGE: result = range_val;
        SEL_MIN:   result = min_reg;
        SEL_MAX:   result = max_reg;
        SEL_COUNT: result = WIDTH'(count_reg);
        default:   result = '0;
      endcase
    end
  end

  assign count     = count_reg;
  assign state_out = state_reg;
  assign valid     = (state_reg == ST_DONE);
  assign error     = (state_reg == ST_ERROR);

`ifdef RANGE_STATS_SEG7_EN
  seg7 u_seg7 (
    .digit    (result[3:0]),
    .segments (segments)
  );
`endif

endmodule

// File: tb/tb_range_stats.sv
// Scoreboard bench for range_stats: directed sessions plus random strobes, checked
// against a sample-list reference model.
module tb_range_stats;

  localparam int WIDTH = 12;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             go;
  logic             finish;
  logic [1:0]       sel;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] count;
  logic [1:0]       state_out;
  logic             valid;
  logic             error;
`ifdef RANGE_STATS_SEG7_EN
  logic [6:0]       segments;
`endif

  range_stats #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in),
    .go        (go),
    .finish    (finish),
    .sel       (sel),
    .result    (result),
    .count     (count),
    .state_out (state_out),
    .valid     (valid),
    .error     (error)
`ifdef RANGE_STATS_SEG7_EN
    ,
    .segments  (segments)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int st;
    int cnt;
    int res;
    int tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: the list of samples of the current session plus a state code.
  int m_st = 0;
  int m_samples[$];

  function automatic void check(input string name, input int tag, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s step=%0d got=%0d expected=%0d", name, tag, act, want);
    end
  endfunction

  function automatic int seg_pattern(input int d);
    int pat[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                    'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};
    return pat[d & 15];
  endfunction

  int step_no = 0;

  task automatic step(input bit r, input bit g, input bit f, input int d, input int s);
    exp_t e;
    int   lo, hi, n;
    @(negedge clock);
    reset   = r;
    go      = g;
    finish  = f;
    data_in = d[WIDTH-1:0];
    sel     = s[1:0];
    if (r) begin
      m_st = 0;
      m_samples.delete();
    end else if (g && f) begin
      m_st = 3;
    end else if (g) begin
      if (m_st != 1) m_samples.delete();
      m_samples.push_back(d & ((1 << WIDTH) - 1));
      m_st = 1;
    end else if (f) begin
      m_st = (m_st == 1) ? 2 : 3;
    end
    n  = m_samples.size();
    lo = (1 << WIDTH) - 1;
    hi = 0;
    foreach (m_samples[i]) begin
      if (m_samples[i] < lo) lo = m_samples[i];
      if (m_samples[i] > hi) hi = m_samples[i];
    end
    e.st  = m_st;
    e.cnt = (n > CMAX) ? CMAX : n;
    e.res = 0;
    if (m_st == 2) begin
      case (s & 3)
        0: e.res = hi - lo;
        1: e.res = lo;
        2: e.res = hi;
        default: e.res = e.cnt;
      endcase
    end
    e.tag = step_no;
    step_no++;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle that has an expectation queued, compare just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state", e.tag, int'(state_out), e.st);
        check("count", e.tag, int'(count), e.cnt);
        check("result", e.tag, int'(result), e.res);
        check("valid", e.tag, int'(valid), (e.st == 2) ? 1 : 0);
        check("error", e.tag, int'(error), (e.st == 3) ? 1 : 0);
`ifdef RANGE_STATS_SEG7_EN
        check("segments", e.tag, int'(segments), seg_pattern(e.res));
`endif
      end
    end
  end

  initial begin
    int r, g, f, d, s, waited;
    reset = 1'b1; go = 1'b0; finish = 1'b0; data_in = '0; sel = 2'd0;

    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 77, 3);
    step(0, 0, 0, 0, 0);

    // Three-sample session, then every select in DONE.
    step(0, 1, 0, 5, 0);
    step(0, 1, 0, 200, 0);
    step(0, 1, 0, 17, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 1; i < 4; i++) step(0, 0, 0, 0, i);

    // Finish from DONE and from IDLE goes to ERROR; recovery with a single sample.
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 1, 0, 9, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 2);

    // Strobe collision mid-session holds the statistics.
    step(0, 1, 0, 3, 0);
    step(0, 1, 0, 7, 0);
    step(0, 1, 1, 1, 3);
    step(0, 0, 0, 0, 0);

    // Counter saturation.
    for (int i = 0; i < CMAX + 5; i++) step(0, 1, 0, $urandom_range(4095), 0);
    step(0, 0, 1, 0, 3);
    step(0, 0, 0, 0, 0);

    // Reset mid-session discards partial statistics.
    step(0, 1, 0, 100, 0);
    step(0, 1, 0, 50, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 4095, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 2);

    // Range 0x0A3 for the segment decoder.
    step(0, 1, 0, 'h010, 0);
    step(0, 1, 0, 'h0B3, 0);
    step(0, 0, 1, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(99) < 2) ? 1 : 0;
      g = ($urandom_range(99) < 60) ? 1 : 0;
      f = ($urandom_range(99) < 20) ? 1 : 0;
      d = $urandom_range(4095);
      s = $urandom_range(3);
      step(r[0], g[0], f[0], d, s);
    end

    @(negedge clock);
    go = 1'b0; finish = 1'b0; reset = 1'b0;
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    n_cmp++;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
